moore_pattern_gen: RTL
======================

// Module: moore_pattern_gen
// PURPOSE
//  Serial pattern transmitter, the sending end of our serial pattern detectors.
//  Latches a PAT_W-bit pattern and a repeat count on start.
//  Shifts the pattern out MSB-first, one bit per clk, repeat_n times, with
//  GAP idle cycles between repetitions.
//  Moore FSM: every output is a function of registered state only.
//  Used as stimulus source / link driver feeding the detector FSMs.
// PARAMETERS
//  PAT_W  4  pattern length in bits (>=2)
//  CNT_W  8  width of repeat counter
//  GAP    0  idle cycles (dout=0, valid=0) inserted between repetitions (0..15)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, synchronous, active-high
//  start        in   1      request; sampled only in IDLE
//  pattern_in   in   PAT_W  pattern, latched when start accepted
//  repeat_n     in   CNT_W  repetitions, latched when start accepted
//  dout         out  1      serial data; forced 0 whenever valid=0
//  valid        out  1      dout carries a pattern bit this cycle
//  frame_start  out  1      high while the MSB of each repetition is on dout
//  busy         out  1      high in SEND, GAP and DONE
//  done         out  1      one-cycle pulse after the last bit
// BEHAVIOUR
//  States: IDLE, SEND, GAP, DONE. Registers: state, pat_q, bit_idx, rep_cnt,
//   gap_cnt.
//  Reset: state=IDLE, all counters 0. Outputs dout/valid/frame_start/busy/done
//   all read 0 from the edge rst is sampled high. Reset mid-frame aborts it
//   with no done pulse.
//  IDLE: all outputs 0.
//   - start=1, repeat_n!=0: latch pattern_in/repeat_n, bit_idx=PAT_W-1 -> SEND.
//   - start=1, repeat_n==0: -> DONE; no bits sent.
//  SEND: valid=1, dout=pat_q[bit_idx], frame_start=(bit_idx==PAT_W-1).
//   - Each bit is held exactly one cycle; bit_idx decrements.
//   - At bit_idx==0 the repetition ends and rep_cnt decrements.
//   - If repetitions remain: GAP>0 -> GAP; GAP==0 -> SEND with bit_idx reloaded.
//     Back-to-back repetitions have no bubble.
//   - If this was the last repetition -> DONE.
//  GAP: valid=0, dout=0, held exactly GAP cycles, then -> SEND at MSB.
//  DONE: done=1, busy=1 for one cycle, then -> IDLE.
//  Latency: start high at edge k -> MSB on dout during cycle k..k+1.
//   Total busy = repeat_n*PAT_W + (repeat_n-1)*GAP + 1 cycles.
//  start is ignored in SEND/GAP/DONE. pattern_in/repeat_n changes after
//   acceptance have no effect. A new start is accepted only in IDLE, so
//   there is a minimum of 1 idle cycle between jobs.
//  rep_cnt is CNT_W bits; repeat_n=2^CNT_W-1 sends that many repetitions
//   with no wrap. bit_idx is clog2(PAT_W) bits.
// TESTING
//  T1 reset: rst=1 for 2 cycles, start=1 -> all outputs 0, start ignored,
//     state IDLE.
//  T2 single: PAT_W=4, pattern 4'b1101, repeat_n=1, GAP=0 ->
//     dout 1,1,0,1 with valid=1 for 4 cycles, frame_start only on first, then
//     done for 1 cycle, busy high 5 cycles.
//  T3 repeat+gap: pattern 4'b1011, repeat_n=3, GAP=2 ->
//     1011,00,1011,00,1011. valid low exactly in the 2 gap cycles.
//     3 frame_start pulses, done at cycle 17 after accept.
//  T4 zero/ignore: repeat_n=0 -> valid never high, done 1 cycle after start.
//     start pulsed mid-SEND -> ignored, bit stream unchanged.
//  T5 abort: rst asserted after 2nd bit of a repeat_n=5 job -> outputs 0 next
//     edge, no done. A fresh start then sends the full new pattern.
//  T6 loopback: pattern 4'b1101, repeat_n=4, GAP=0 feeding a detector ->
//     detector output matches a reference model bit-for-bit.
//     Random pattern/repeat/GAP over 1000 jobs, scoreboard compares stream.

Source files
------------

// File: rtl/moore_pattern_gen.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first,
// repeat_n times, with GAP idle cycles between repetitions. Moore outputs, all registered.
module moore_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             dout,
  output logic             valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(PAT_W - 1);
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [PAT_W-1:0] pat_q, pat_next;
  logic [IDX_W-1:0] bit_idx, bit_next;
  logic [CNT_W-1:0] rep_cnt, rep_next;
  logic [3:0]       gap_cnt, gap_next;

  always_comb begin
    state_next = state;
    pat_next   = pat_q;
    bit_next   = bit_idx;
    rep_next   = rep_cnt;
    gap_next   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (repeat_n != '0) begin
            pat_next   = pattern_in;
            rep_next   = repeat_n;
            bit_next   = MSB_IDX;
            state_next = S_SEND;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (bit_idx == '0) begin
          rep_next = rep_cnt - ONE_REP;
          if (rep_cnt == ONE_REP) begin
            state_next = S_DONE;
          end else if (GAP > 0) begin
            gap_next   = GAP_LOAD;
            state_next = S_GAP;
          end else begin
            // Back-to-back repetitions: reload the MSB with no bubble.
            bit_next = MSB_IDX;
          end
        end else begin
          bit_next = bit_idx - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          bit_next   = MSB_IDX;
          state_next = S_SEND;
        end else begin
          gap_next = gap_cnt - 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pat_q       <= '0;
      bit_idx     <= '0;
      rep_cnt     <= '0;
      gap_cnt     <= '0;
      dout        <= 1'b0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      pat_q       <= pat_next;
      bit_idx     <= bit_next;
      rep_cnt     <= rep_next;
      gap_cnt     <= gap_next;
      valid       <= (state_next == S_SEND);
      dout        <= (state_next == S_SEND) && pat_next[bit_next];
      frame_start <= (state_next == S_SEND) && (bit_next == MSB_IDX);
      busy        <= (state_next != S_IDLE);
      done        <= (state_next == S_DONE);
    end
  end

endmodule
